// File: rtl/mdr_seq_multiplier.sv
// Iterative shift-add multiplier feeding the MDR result demux (product + held route select).
// Optional feature macro MDR_SIGNED_EN: two's-complement operands via magnitude multiply + final negate.
module mdr_seq_multiplier #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DW-1:0]     multiplicand_i,
  input  logic [DW-1:0]     multiplier_i,
  input  logic [1:0]        sel_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [2*DW-1:0]   product_o,
  output logic [1:0]        sel_o
);

  localparam int DW_DBL = 2*DW - 1;
  localparam int CW     = $clog2(DW) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
`ifdef MDR_SIGNED_EN
    S_SIGN = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW:0]       acc_hi_q, acc_hi_d;
  logic [DW-1:0]     acc_lo_q, acc_lo_d;
  logic [DW-1:0]     mcand_q, mcand_d;
  logic [DW-1:0]     opa_q, opa_d;
  logic [DW-1:0]     opb_q, opb_d;
  logic [1:0]        sel_cap_q, sel_cap_d;
  logic [DW_DBL:0]   product_q, product_d;
  logic [1:0]        sel_q, sel_d;
  logic              done_q, done_d;

  logic [DW:0]       run_sum;
  logic [DW_DBL:0]   full_acc;

  assign run_sum  = acc_lo_q[0] ? (acc_hi_q + {1'b0, mcand_q}) : acc_hi_q;
  assign full_acc = {acc_hi_q[DW-1:0], acc_lo_q};

`ifdef MDR_SIGNED_EN
  logic              neg_q, neg_d;
  logic [DW_DBL:0]   neg_acc;

  // Magnitude of a two's-complement value; the most-negative value maps to 2^(DW-1) unsigned.
  function automatic logic [DW-1:0] abs_val(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    if (v[DW-1]) begin
      r = ~v + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign neg_acc = ~full_acc + {{DW_DBL{1'b0}}, 1'b1};
`endif

  // Next-state, datapath and output-register update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sel_cap_d = sel_cap_q;
    product_d = product_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
`ifdef MDR_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          opa_d     = multiplicand_i;
          opb_d     = multiplier_i;
          sel_cap_d = sel_i;
          state_d   = S_LOAD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_LOAD: begin
        acc_hi_d = '0;
        cnt_d    = '0;
`ifdef MDR_SIGNED_EN
        acc_lo_d = abs_val(opb_q);
        mcand_d  = abs_val(opa_q);
        neg_d    = opa_q[DW-1] ^ opb_q[DW-1];
`else
        acc_lo_d = opb_q;
        mcand_d  = opa_q;
`endif
        state_d  = S_RUN;
      end
      S_RUN: begin
        // Add-then-shift: the sum's LSB drops into the top of acc_lo.
        acc_hi_d = {1'b0, run_sum[DW:1]};
        acc_lo_d = {run_sum[0], acc_lo_q[DW-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) begin
`ifdef MDR_SIGNED_EN
          state_d = S_SIGN;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RUN;
        end
      end
`ifdef MDR_SIGNED_EN
      S_SIGN: begin
        if (neg_q) begin
          acc_hi_d = {1'b0, neg_acc[DW_DBL:DW]};
          acc_lo_d = neg_acc[DW-1:0];
        end else begin
          acc_hi_d = acc_hi_q;
          acc_lo_d = acc_lo_q;
        end
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        product_d = full_acc;
        sel_d     = sel_cap_q;
        done_d    = 1'b1;
        if (start_i) begin
          opa_d     = multiplicand_i;
          opb_d     = multiplier_i;
          sel_cap_d = sel_i;
          state_d   = S_LOAD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      sel_cap_q <= 2'b00;
      product_q <= '0;
      sel_q     <= 2'b00;
      done_q    <= 1'b0;
`ifdef MDR_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sel_cap_q <= sel_cap_d;
      product_q <= product_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
`ifdef MDR_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign ready_o   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done_o    = done_q;
  assign product_o = product_q;
  assign sel_o     = sel_q;

endmodule

// File: tb/tb_mdr_seq_multiplier.sv
// Self-checking bench for mdr_seq_multiplier: vector table, corner-case sequences, random ops vs arithmetic model.
module tb_mdr_seq_multiplier;

  localparam int DW = 8;
`ifdef MDR_SIGNED_EN
  localparam int LAT = DW + 3;
`else
  localparam int LAT = DW + 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  a_i, b_i;
  logic [1:0]  sel_i;
  logic        ready_o, done_o;
  logic [15:0] product_o;
  logic [1:0]  sel_o;

  int n_tests = 0;
  int n_fail  = 0;

  mdr_seq_multiplier #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .multiplicand_i(a_i), .multiplier_i(b_i), .sel_i(sel_i),
    .ready_o(ready_o), .done_o(done_o), .product_o(product_o), .sel_o(sel_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  s;
    logic [15:0] exp_u;
    logic [15:0] exp_s;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int p;
`ifdef MDR_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[15:0];
  endfunction

  // One operation; optionally pulses a stray start at cycle ign_at which must be ignored.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                        input logic [15:0] exp, input string name, input int ign_at);
    logic [15:0] prev_p;
    logic [1:0]  prev_s;
    int lat;
    bit held;
    prev_p = product_o;
    prev_s = sel_o;
    check({name, " ready"}, ready_o, 1);
    a_i = a; b_i = b; sel_i = s; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = 8'($urandom); b_i = 8'($urandom); sel_i = 2'($urandom);
    lat = 0;
    held = 1'b1;
    while (!done_o && lat < 40) begin
      if (product_o !== prev_p || sel_o !== prev_s) held = 1'b0;
      if (lat == ign_at) begin
        start_i = 1'b1; a_i = 8'h01; b_i = 8'h01;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    check({name, " latency"}, lat, LAT);
    check({name, " product"}, product_o, exp);
    check({name, " sel"}, sel_o, s);
    check({name, " hold"}, held, 1);
    @(posedge clk); #1;
    check({name, " pulse"}, done_o, 0);
  endtask

  initial begin
    int t, dones;
    logic [7:0] ra, rb;
    logic [1:0] rs;

    vecs[0] = '{8'hFF, 8'hFF, 2'b10, 16'hFE01, 16'h0001};
    vecs[1] = '{8'h00, 8'hA5, 2'b01, 16'h0000, 16'h0000};
    vecs[2] = '{8'h12, 8'h34, 2'b11, 16'h03A8, 16'h03A8};
    vecs[3] = '{8'hFF, 8'h01, 2'b00, 16'h00FF, 16'hFFFF};
    vecs[4] = '{8'h80, 8'h80, 2'b10, 16'h4000, 16'h4000};
    vecs[5] = '{8'h7F, 8'h80, 2'b01, 16'h3F80, 16'hC080};
    vecs[6] = '{8'h01, 8'hFF, 2'b11, 16'h00FF, 16'hFFFF};
    vecs[7] = '{8'hA5, 8'h00, 2'b00, 16'h0000, 16'h0000};
    vecs[8] = '{8'hFF, 8'h80, 2'b01, 16'h7F80, 16'h0080};

    rst = 1'b1; start_i = 1'b0; a_i = 8'h00; b_i = 8'h00; sel_i = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset product", product_o, 0);
    check("reset sel", sel_o, 0);
    check("reset done", done_o, 0);
    check("reset ready", ready_o, 1);

    for (int i = 0; i < 9; i++) begin
`ifdef MDR_SIGNED_EN
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_s, $sformatf("vec%0d", i), -1);
`else
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_u, $sformatf("vec%0d", i), -1);
`endif
    end

    // Stray start during RUN must not disturb 12*34.
    run_op(8'h12, 8'h34, 2'b01, model(8'h12, 8'h34), "ignore", 4);

    // Back-to-back: start held in the DONE cycle.
    a_i = 8'h0F; b_i = 8'h11; sel_i = 2'b10; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    t = 0;
    while (!ready_o && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("b2b ready cycle", t, LAT - 1);
    a_i = 8'hC3; b_i = 8'h5A; sel_i = 2'b01; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("b2b first done", done_o, 1);
    check("b2b first product", product_o, model(8'h0F, 8'h11));
    check("b2b first sel", sel_o, 2'b10);
    t = 0;
    while (t < 40) begin
      @(posedge clk); #1;
      t++;
      if (done_o) break;
    end
    check("b2b spacing", t, LAT);
    check("b2b second product", product_o, model(8'hC3, 8'h5A));
    check("b2b second sel", sel_o, 2'b01);
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts with no done.
    a_i = 8'h0F; b_i = 8'h0F; sel_i = 2'b11; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst product", product_o, 0);
    check("midrst sel", sel_o, 0);
    check("midrst done", done_o, 0);
    check("midrst ready", ready_o, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    check("midrst no done", dones, 0);
    check("midrst ready after", ready_o, 1);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 2'($urandom);
      if (i == 0) ra = 8'h00;
      run_op(ra, rb, rs, model(ra, rb), $sformatf("rand%0d %0h*%0h", i, ra, rb), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
